ps2_host_tx: RTL

- PS/2 host-to-device transmitter; sends one command byte (e.g. 0xED set-LEDs, 0xF4 enable mouse reporting) to a keyboard or mouse.
- Complements the existing PS/2 receive path; one instance on the keyboard port, one on the mouse port.
- Drives the open-collector clock and data lines through active-low enables; the top level builds the tristates.
- Raises busy so the receive path ignores bus activity while a command is in flight.

---
 rtl/ps2_pkg.sv | 37 +++
 rtl/ps2_line_filter.sv | 46 ++++
 rtl/ps2_host_tx.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : ps2_pkg
// Brief  : Shared types and timing helpers for the PS/2 host transmitter
//          and the receive path.
// Rev    : 1.0  initial release
// ============================================================================
package ps2_pkg;

  // Transmitter sequencing states
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    INHIBIT  = 3'd1,
    SHIFT    = 3'd2,
    ACK      = 3'd3,
    WAITIDLE = 3'd4
  } ps2_state_t;

  // Frame slot indices following the eight data bits
  localparam int unsigned PARITY_BIT = 8;
  localparam int unsigned STOP_BIT   = 9;

  // Inhibit length in clk cycles; 64-bit math avoids overflow of freq*us
  function automatic int unsigned inh_cycles(input longint unsigned clkfreq,
                                             input longint unsigned us);
    return 32'(clkfreq * us / 64'd1000000);
  endfunction

  // Timeout length in clk cycles (MHz first, then scaled by the microseconds)
  function automatic int unsigned to_cycles(input longint unsigned clkfreq,
                                            input longint unsigned us);
    return 32'((clkfreq / 64'd1000000) * us);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_line_filter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : ps2_line_filter
// Brief  : 2-FF synchroniser, 4-sample deglitch and falling-edge strobe for
//          one open-collector PS/2 line.
// Rev    : 1.0  initial release
// ============================================================================
module ps2_line_filter (
  input  logic clk,
  input  logic rst,
  input  logic i_line,
  output logic o_filt,
  output logic o_fall
);

  logic [1:0] r_sync;
  logic [3:0] r_hist;
  logic       r_filt;
  logic       r_fall;

  // Synchronise, keep the last four samples, and move the filtered level
  // only when all four agree; the idle bus level is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= 2'b11;
      r_hist <= 4'hF;
      r_filt <= 1'b1;
      r_fall <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_line};
      r_hist <= {r_hist[2:0], r_sync[1]};
      r_fall <= r_filt && (r_hist == 4'h0);
      if (r_hist == 4'hF) begin
        r_filt <= 1'b1;
      end else if (r_hist == 4'h0) begin
        r_filt <= 1'b0;
      end
    end
  end

  assign o_filt = r_filt;
  assign o_fall = r_fall;

endmodule
`default_nettype wire

// File: rtl/ps2_host_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : ps2_host_tx
// Brief  : PS/2 host-to-device command transmitter. Inhibits the bus, issues
//          a request-to-send, shifts out data/parity/stop on device clock
//          falls, checks the acknowledge and waits for the bus to go idle.
// Rev    : 1.0  initial release
// ============================================================================
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned CLKFREQ    = 28000000,
  parameter int unsigned INHIBIT_US = 100,
  parameter int unsigned TIMEOUT_US = 15000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2clk_in,
  input  logic       ps2data_in,
  output logic       ps2clk_oe,
  output logic       ps2data_oe,
  input  logic [7:0] data,
  input  logic       send,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int unsigned c_INH_CYC = inh_cycles(64'(CLKFREQ), 64'(INHIBIT_US));
  localparam int unsigned c_TO_CYC  = to_cycles(64'(CLKFREQ), 64'(TIMEOUT_US));
  localparam int unsigned c_TMR_MAX = (c_TO_CYC > c_INH_CYC) ? c_TO_CYC : c_INH_CYC;
  localparam int          c_TMR_W   = $clog2(c_TMR_MAX + 1);

  localparam logic [c_TMR_W-1:0] c_INH_LAST = c_TMR_W'(c_INH_CYC - 1);
  localparam logic [c_TMR_W-1:0] c_TO_LAST  = c_TMR_W'(c_TO_CYC - 1);
  localparam logic [3:0]         c_PAR_IDX  = 4'(PARITY_BIT);
  localparam logic [3:0]         c_STOP_IDX = 4'(STOP_BIT);

  logic w_clk_filt;
  logic w_clk_fall;
  logic w_data_filt;
  logic w_data_fall_unused;
  logic w_timeout;

  ps2_state_t         r_state;
  logic [7:0]         r_shreg;
  logic               r_par;
  logic [3:0]         r_bitcnt;
  logic [c_TMR_W-1:0] r_timer;
  logic               r_clk_oe;
  logic               r_data_oe;
  logic               r_busy;
  logic               r_done;
  logic               r_error;

  ps2_line_filter u_clk_filter (
    .clk    (clk),
    .rst    (rst),
    .i_line (ps2clk_in),
    .o_filt (w_clk_filt),
    .o_fall (w_clk_fall)
  );

  ps2_line_filter u_data_filter (
    .clk    (clk),
    .rst    (rst),
    .i_line (ps2data_in),
    .o_filt (w_data_filt),
    .o_fall (w_data_fall_unused)
  );

  assign w_timeout = (r_timer == c_TO_LAST);

  // Transfer sequencer: all outputs are registered; done/error are one-cycle
  // pulses and the timeout takes priority over any bus event in its cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_shreg   <= 8'h00;
      r_par     <= 1'b0;
      r_bitcnt  <= 4'd0;
      r_timer   <= '0;
      r_clk_oe  <= 1'b0;
      r_data_oe <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
    end else begin
      r_done  <= 1'b0;
      r_error <= 1'b0;
      case (r_state)
        IDLE: begin
          // A request coinciding with the previous completion pulse is dropped
          if (send && !r_done && !r_error) begin
            r_shreg  <= data;
            r_par    <= ~^data;
            r_bitcnt <= 4'd0;
            r_timer  <= '0;
            r_busy   <= 1'b1;
            r_clk_oe <= 1'b1;
            r_state  <= INHIBIT;
          end
        end

        INHIBIT: begin
          if (r_timer == c_INH_LAST) begin
            r_data_oe <= 1'b1;
            r_clk_oe  <= 1'b0;
            r_timer   <= '0;
            r_state   <= SHIFT;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end

        SHIFT: begin
          if (w_timeout) begin
            r_clk_oe  <= 1'b0;
            r_data_oe <= 1'b0;
            r_busy    <= 1'b0;
            r_error   <= 1'b1;
            r_state   <= IDLE;
          end else begin
            r_timer <= r_timer + 1'b1;
            if (w_clk_fall) begin
              r_bitcnt <= r_bitcnt + 1'b1;
              if (r_bitcnt < c_PAR_IDX) begin
                r_data_oe <= ~r_shreg[r_bitcnt[2:0]];
              end else if (r_bitcnt == c_PAR_IDX) begin
                r_data_oe <= ~r_par;
              end else begin
                // Stop slot: release data; anything past it is the ack slot
                r_data_oe <= 1'b0;
                if (r_bitcnt >= c_STOP_IDX) begin
                  r_state <= ACK;
                end
              end
            end
          end
        end

        ACK: begin
          if (w_timeout) begin
            r_clk_oe  <= 1'b0;
            r_data_oe <= 1'b0;
            r_busy    <= 1'b0;
            r_error   <= 1'b1;
            r_state   <= IDLE;
          end else begin
            r_timer <= r_timer + 1'b1;
            if (w_clk_fall) begin
              if (!w_data_filt) begin
                r_state <= WAITIDLE;
              end else begin
                r_busy  <= 1'b0;
                r_error <= 1'b1;
                r_state <= IDLE;
              end
            end
          end
        end

        WAITIDLE: begin
          if (w_timeout) begin
            r_clk_oe  <= 1'b0;
            r_data_oe <= 1'b0;
            r_busy    <= 1'b0;
            r_error   <= 1'b1;
            r_state   <= IDLE;
          end else begin
            r_timer <= r_timer + 1'b1;
            if (w_clk_filt && w_data_filt) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= IDLE;
            end
          end
        end

        default: begin
          r_clk_oe  <= 1'b0;
          r_data_oe <= 1'b0;
          r_busy    <= 1'b0;
          r_state   <= IDLE;
        end
      endcase
    end
  end

  assign ps2clk_oe  = r_clk_oe;
  assign ps2data_oe = r_data_oe;
  assign busy       = r_busy;
  assign done       = r_done;
  assign error      = r_error;

endmodule
`default_nettype wire
